uart_tx_arbiter: RTL and testbench

- Shares one serial TX line among NUM_REQ byte-producing clients, with round-robin arbitration.
- Contains its own bit-timing counter, driven by a runtime-programmable divisor. This replaces a fixed-rate baud enable with a configurable one.
- Sits between internal clients (debug/status producers) and the board UART pin.
- Frames are 8N1: 1 start bit, 8 data bits LSB first, 1 stop bit.

---
 rtl/uart_tx_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART TX line among NUM_REQ clients.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DIV_W   = 16,
   localparam int IDX_W  = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [DIV_W-1:0]     baud_div,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ*8-1:0] req_data,
   output logic [NUM_REQ-1:0]   grant,
   output logic [IDX_W-1:0]     owner,
   output logic                 busy,
   output logic                 tx
);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE, START, DATA, STOP
   } state_t;
`endif

   state_t           state_q, state_d;
   logic [DIV_W-1:0] tick_q, tick_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] owner_q, owner_d;
`ifdef UART_TX_PARITY_EN
   logic             par_q, par_d;
`endif

   logic             arb_en;
   logic             hi_found, lo_found, found;
   logic [IDX_W-1:0] hi_sel, lo_sel, sel;
   logic [7:0]       sel_byte;
   logic [NUM_REQ-1:0] gnt;
   logic             bit_end;

   // Search above ptr first, then wrap to the low half.
   always_comb begin
      arb_en   = (state_q == IDLE) && reset_n;
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_sel   = '0;
      lo_sel   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            if (IDX_W'(i) > ptr_q) begin
               hi_found = 1'b1;
               hi_sel   = IDX_W'(i);
            end else begin
               lo_found = 1'b1;
               lo_sel   = IDX_W'(i);
            end
         end
      end
      found    = hi_found || lo_found;
      sel      = hi_found ? hi_sel : lo_sel;
      sel_byte = '0;
      gnt      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (sel == IDX_W'(i)) begin
            sel_byte = req_data[i*8 +: 8];
            gnt[i]   = arb_en && found;
         end
      end
   end

   assign bit_end = (tick_q == div_q);

   always_comb begin
      state_d = state_q;
      tick_d  = '0;
      div_d   = div_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      if (state_q != IDLE && !bit_end) begin
         tick_d = tick_q + DIV_W'(1);
      end
      unique case (state_q)
         IDLE: begin
            bit_d = '0;
            if (arb_en && found) begin
               shift_d = sel_byte;
               div_d   = baud_div;
               owner_d = sel;
               ptr_d   = sel;
`ifdef UART_TX_PARITY_EN
               par_d   = ^sel_byte;
`endif
               state_d = START;
            end
         end
         START: begin
            if (bit_end) state_d = DATA;
         end
         DATA: begin
            if (bit_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) state_d = STOP;
         end
`endif
         STOP: begin
            if (bit_end) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         tick_q  <= '0;
         div_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         ptr_q   <= IDX_W'(NUM_REQ - 1);
         owner_q <= '0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // Line level decodes straight from state so reset forces idle-high at once.
   always_comb begin
      tx = 1'b1;
      unique case (state_q)
         START:   tx = 1'b0;
         DATA:    tx = shift_q[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx = par_q;
`endif
         default: tx = 1'b1;
      endcase
   end

   assign grant = gnt;
   assign owner = owner_q;
   assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a frame-level model.
// Model: round-robin pick from a pointer, then a list of line bits.
module tb_uart_tx_arbiter;
   localparam int N  = 4;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [DW-1:0] baud_div;
   logic [N-1:0]  req;
   logic [N*8-1:0] req_data;
   logic [N-1:0]  grant;
   logic [1:0]    owner;
   logic          busy;
   logic          tx;

   int n_vec = 0;
   int n_err = 0;
   int ptr_m;
   int owner_m;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(N), .DIV_W(DW)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .baud_div (baud_div),
      .req      (req),
      .req_data (req_data),
      .grant    (grant),
      .owner    (owner),
      .busy     (busy),
      .tx       (tx)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int k = 1; k <= N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   // Called at posedge+1 of an idle cycle with inputs driven.
   task automatic arb_cycle(input bit scr, input int mid_div);
      int         w;
      int         div;
      logic [7:0] b;
      int         bits[$];
      @(negedge clk);
      w = pick(req, ptr_m);
      chk("owner_idle", 32'(owner), 32'(owner_m));
      chk("busy_idle", 32'(busy), 32'd0);
      chk("tx_idle", 32'(tx), 32'd1);
      if (w < 0) begin
         chk("grant_none", 32'(grant), 32'd0);
         return;
      end
      chk("grant", 32'(grant), 32'(1 << w));
      b       = 8'(req_data >> (w * 8));
      div     = int'(baud_div);
      ptr_m   = w;
      owner_m = w;
      bits    = {};
      bits.push_back(0);
      for (int i = 0; i < 8; i++) bits.push_back(int'(b[i]));
`ifdef UART_TX_PARITY_EN
      bits.push_back(int'(^b));
`endif
      bits.push_back(1);
      foreach (bits[j]) begin
         for (int c = 0; c <= div; c++) begin
            step();
            if (scr) begin
               req      = N'($urandom_range(0, 15));
               req_data = $urandom;
               baud_div = DW'($urandom_range(0, 3));
            end else if (mid_div >= 0) begin
               baud_div = DW'(mid_div);
            end
            @(negedge clk);
            chk("tx", 32'(tx), 32'(bits[j]));
            chk("busy", 32'(busy), 32'd1);
            chk("grant_busy", 32'(grant), 32'd0);
            chk("owner", 32'(owner), 32'(w));
         end
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      req     = '0;
      ptr_m   = N - 1;
      owner_m = 0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n  = 1'b0;
      req      = '0;
      req_data = '0;
      baud_div = '0;
      do_reset();

      // idle after reset
      repeat (100) begin
         @(negedge clk);
         chk("rst_tx", 32'(tx), 32'd1);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_grant", 32'(grant), 32'd0);
         chk("rst_owner", 32'(owner), 32'd0);
         step();
      end

      // single 0xA5 frame, 4-cycle bits
      req      = 4'b0001;
      req_data = 32'h0000_00A5;
      baud_div = 16'd3;
      arb_cycle(1'b0, -1);
      step();
      req = '0;
      arb_cycle(1'b0, -1);
      step();

      // four clients, one cycle per bit
      do_reset();
      req      = 4'b1111;
      req_data = $urandom;
      baud_div = 16'd0;
      repeat (4) begin
         arb_cycle(1'b0, -1);
         step();
      end
      req = '0;

      // divisor change mid-frame only affects the next frame
      do_reset();
      req      = 4'b0100;
      req_data = $urandom;
      baud_div = 16'd2;
      arb_cycle(1'b0, 7);
      step();
      arb_cycle(1'b0, -1);
      step();
      req = '0;

      // asynchronous reset during DATA
      do_reset();
      req      = 4'b0010;
      req_data = $urandom;
      baud_div = 16'd3;
      @(negedge clk);
      chk("grant_c1", 32'(grant), 32'h2);
      repeat (20) begin
         step();
         @(negedge clk);
         chk("busy_pre", 32'(busy), 32'd1);
      end
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_tx", 32'(tx), 32'd1);
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_grant", 32'(grant), 32'd0);
      chk("async_owner", 32'(owner), 32'd0);
      ptr_m   = N - 1;
      owner_m = 0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      arb_cycle(1'b0, -1);
      step();
      req = '0;

`ifdef UART_TX_PARITY_EN
      do_reset();
      req      = 4'b0001;
      req_data = 32'h0000_0007;
      baud_div = 16'd0;
      arb_cycle(1'b0, -1);
      step();
      req = '0;
`endif

      // random traffic with inputs scrambled while busy
      do_reset();
      repeat (60) begin
         req      = N'($urandom_range(0, 15));
         req_data = $urandom;
         baud_div = DW'($urandom_range(0, 3));
         arb_cycle(1'b1, -1);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
